// File: rtl/fp_div.sv
// fp_div: free-running binary32 divider (restoring radix-2 + round-to-nearest-even), 29-cycle period.
// Define FP_DIV_EXC_FLAGS_EN to add flags[3:0] = {invalid, div_by_zero, overflow, underflow}.
module fp_div (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
`ifdef FP_DIV_EXC_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic        valid_out,
    output logic [31:0] S
);

    typedef enum logic [1:0] {LOAD, CALC, NORM, ROUND} state_t;
    typedef enum logic [2:0] {K_NORMAL, K_NAN, K_INF, K_DBZ, K_ZERO} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic        sign_q, sign_d;
    logic [24:0] r_q, r_d;
    logic [23:0] mb_q, mb_d;
    logic [25:0] q_q, q_d;
    logic [23:0] mant_q, mant_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [9:0]  e_q, e_d;
    logic [31:0] s_q, s_d;
    logic        valid_q, valid_d;
`ifdef FP_DIV_EXC_FLAGS_EN
    logic [3:0]  flags_q, flags_d;
`endif

    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        inc, ovf, unf;
    logic [24:0] mant_r;
    logic [9:0]  e_r;
    logic [22:0] frac;

    // Denormals have exponent 0 and are treated as zero.
    always_comb begin
        a_zero = (num1[30:23] == 8'h00);
        a_inf  = (num1[30:23] == 8'hFF) && (num1[22:0] == '0);
        a_nan  = (num1[30:23] == 8'hFF) && (num1[22:0] != '0);
        b_zero = (num2[30:23] == 8'h00);
        b_inf  = (num2[30:23] == 8'hFF) && (num2[22:0] == '0);
        b_nan  = (num2[30:23] == 8'hFF) && (num2[22:0] != '0);
    end

    always_comb begin
        inc    = guard_q & (sticky_q | mant_q[0]);
        mant_r = {1'b0, mant_q} + {24'b0, inc};
        e_r    = e_q + {9'b0, mant_r[24]};
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        ovf    = (kind_q == K_NORMAL) && ($signed(e_r) >= $signed(10'd255));
        unf    = (kind_q == K_NORMAL) && ($signed(e_r) <= $signed(10'd0));
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        sign_d   = sign_q;
        r_d      = r_q;
        mb_d     = mb_q;
        q_d      = q_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        e_d      = e_q;
        s_d      = s_q;
        valid_d  = 1'b0;
`ifdef FP_DIV_EXC_FLAGS_EN
        flags_d  = flags_q;
`endif
        case (state_q)
            LOAD: begin
                ea_d   = num1[30:23];
                eb_d   = num2[30:23];
                sign_d = num1[31] ^ num2[31];
                r_d    = {2'b01, num1[22:0]};
                mb_d   = {1'b1, num2[22:0]};
                q_d    = '0;
                cnt_d  = 5'd26;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
                    kind_d = K_NAN;
                else if (a_inf)
                    kind_d = K_INF;
                else if (b_zero)
                    kind_d = K_DBZ;
                else if (a_zero || b_inf)
                    kind_d = K_ZERO;
                else
                    kind_d = K_NORMAL;
                state_d = CALC;
            end
            CALC: begin
                if (r_q >= {1'b0, mb_q}) begin
                    r_d = (r_q - {1'b0, mb_q}) << 1;
                    q_d = {q_q[24:0], 1'b1};
                end else begin
                    r_d = r_q << 1;
                    q_d = {q_q[24:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_d = NORM;
            end
            NORM: begin
                if (q_q[25]) begin
                    mant_d  = q_q[25:2];
                    guard_d = q_q[1];
                end else begin
                    mant_d  = q_q[24:1];
                    guard_d = q_q[0];
                end
                sticky_d = (r_q != '0);
                e_d      = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127 - {9'b0, ~q_q[25]};
                state_d  = ROUND;
            end
            ROUND: begin
                case (kind_q)
                    K_NAN:         s_d = 32'h7FC0_0000;
                    K_INF, K_DBZ:  s_d = {sign_q, 8'hFF, 23'b0};
                    K_ZERO:        s_d = {sign_q, 31'b0};
                    default: begin
                        if (ovf)
                            s_d = {sign_q, 8'hFF, 23'b0};
                        else if (unf)
                            s_d = {sign_q, 31'b0};
                        else
                            s_d = {sign_q, e_r[7:0], frac};
                    end
                endcase
`ifdef FP_DIV_EXC_FLAGS_EN
                flags_d = {kind_q == K_NAN, kind_q == K_DBZ, ovf, unf};
`endif
                valid_d = 1'b1;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= LOAD;
            kind_q   <= K_NORMAL;
            cnt_q    <= '0;
            ea_q     <= '0;
            eb_q     <= '0;
            sign_q   <= 1'b0;
            r_q      <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            e_q      <= '0;
            s_q      <= '0;
            valid_q  <= 1'b0;
`ifdef FP_DIV_EXC_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            sign_q   <= sign_d;
            r_q      <= r_d;
            mb_q     <= mb_d;
            q_q      <= q_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            e_q      <= e_d;
            s_q      <= s_d;
            valid_q  <= valid_d;
`ifdef FP_DIV_EXC_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign S         = s_q;
    assign valid_out = valid_q;
`ifdef FP_DIV_EXC_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed-vector self-checking bench for fp_div (default build).
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] num1, num2;
    logic        valid_out;
    logic [31:0] S;

    int n_checks = 0;
    int n_fail   = 0;

    fp_div dut (
        .clk       (clk),
        .rstn      (rstn),
        .num1      (num1),
        .num2      (num2),
        .valid_out (valid_out),
        .S         (S)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Returns the number of rising edges until valid_out is seen, 0 if none within 40.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                n = i;
                break;
            end
        end
    endtask

    logic [31:0] vec_a [13] = '{32'h3F8E147B, 32'h40AE6666, 32'h42EA75C3, 32'h3F800000,
                                32'hBF800000, 32'h00000000, 32'h7F800000, 32'h7F000000,
                                32'h00800000, 32'h7FC00000, 32'h3F800000, 32'hBF800000,
                                32'h00400000};
    logic [31:0] vec_b [13] = '{32'h3F8147AE, 32'h404D70A4, 32'h40BEB852, 32'h00000000,
                                32'h00000000, 32'h00000000, 32'h3F800000, 32'h3E800000,
                                32'h7F000000, 32'h3F800000, 32'h7F800000, 32'h7F800000,
                                32'h3F800000};
    logic [31:0] vec_s [13] = '{32'h3F8CAC5B, 32'h3FD95224, 32'h419D5B10, 32'h7F800000,
                                32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h7F800000,
                                32'h00000000, 32'h7FC00000, 32'h00000000, 32'h80000000,
                                32'h00000000};

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b1;
        num1 = 32'h3E9EB852;
        num2 = 32'h3F8F5C29;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_S", S, 32'h0);
            check("rst_valid", {31'b0, valid_out}, 32'h0);
        end
        rstn = 1'b0;

        wait_valid(n);
        check("first_latency", n, 32'd29);
        check("first_S", S, 32'h3E8DB6DB);

        @(posedge clk); #1;
        check("valid_pulse_width", {31'b0, valid_out}, 32'h0);
        wait_valid(n);
        check("period", n, 32'd28);
        check("stable_S", S, 32'h3E8DB6DB);

        for (int v = 0; v < 13; v++) begin
            num1 = vec_a[v];
            num2 = vec_b[v];
            wait_valid(n);
            check($sformatf("vec%0d_period", v), n, 32'd29);
            check($sformatf("vec%0d_S", v), S, vec_s[v]);
        end

        // Input change in the middle of CALC must not affect the pending result.
        num1 = 32'h3F8E147B;
        num2 = 32'h3F8147AE;
        repeat (10) @(posedge clk);
        #1 num1 = 32'h40AE6666;
        wait_valid(n);
        check("midcalc_period", n, 32'd19);
        check("midcalc_S", S, 32'h3F8CAC5B);

        // Reset during CALC aborts the operation.
        num1 = 32'h40AE6666;
        num2 = 32'h404D70A4;
        repeat (11) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midrst_S", S, 32'h0);
            check("midrst_valid", {31'b0, valid_out}, 32'h0);
        end
        num1 = 32'h42EA75C3;
        num2 = 32'h40BEB852;
        rstn = 1'b0;
        wait_valid(n);
        check("restart_latency", n, 32'd29);
        check("restart_S", S, 32'h419D5B10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Sequential IEEE-754 single-precision divider for the ALU: S = num1 / num2.
- Free-running: there is no start strobe. The block repeatedly captures num1/num2, computes the quotient over a fixed number of cycles, then updates S and pulses valid_out.
- Mantissa quotient is produced by a radix-2 restoring divider, one quotient bit per cycle, followed by round-to-nearest-even.

Parameters:
- None. Width is fixed at 32-bit binary32.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  synchronous reset, active-high (1 = reset) despite the codebase name
- num1  input  32  dividend, IEEE-754 binary32
- num2  input  32  divisor, IEEE-754 binary32
- valid_out  output  1  one-cycle pulse when S is updated with a new quotient
- S  output  32  quotient, binary32; held between updates

Behaviour:
- Reset (rstn=1 at a clk edge): S=32'h0, valid_out=0, FSM->LOAD, all datapath registers cleared. Reset mid-computation aborts the operation with no valid_out. Reset has priority over everything.
- FSM states: LOAD -> CALC -> NORM -> ROUND -> LOAD.
- LOAD (1 cycle):
  - Register num1/num2, unpack fields, set iteration counter to 26.
  - Inputs are sampled only here; input changes during CALC/NORM/ROUND affect only the next operation.
- CALC (26 cycles), restoring division of 24-bit significands ma=1.fa and mb=1.fb:
  - Initial remainder r=ma.
  - Each cycle: if r>=mb then r-=mb and q bit=1, else q bit=0; then r<<=1. Quotient is shifted in MSB first.
  - Partial remainder is 25 bits; q is 26 bits.
- NORM (1 cycle):
  - If q[25]=1: mant=q[25:2], guard=q[1], and exp adjust 0.
  - Else: mant=q[24:1], guard=q[0], and exp adjust -1.
  - sticky = (final remainder != 0).
  - Biased exponent e = ea - eb + 127 + adjust, computed signed with 10 bits.
- ROUND (1 cycle):
  - Round-to-nearest-even: increment when guard & (sticky | mant[0]). Mantissa carry-out renormalises and sets e += 1.
  - Write S = {sign, e[7:0], mant[22:0]} and assert valid_out for exactly this cycle.
- Total: 29 cycles from LOAD to valid_out; the next LOAD follows immediately, giving a 29-cycle period.
- Sign = num1[31] ^ num2[31] for all results, including zero/inf. NaN results use the sign bit 0.
- Special cases (decided in LOAD, result still delivered on the same 29-cycle schedule):
  - Either operand NaN, 0/0, or inf/inf -> 32'h7FC00000.
  - x/0 with x finite non-zero, or inf/finite -> signed infinity.
  - 0/finite non-zero, or finite/inf -> signed zero.
- Denormal inputs are flushed to zero before special-case decode, and no denormal outputs are produced.
- Overflow (e>=255 after rounding) -> signed infinity.
- Underflow (e<=0) -> signed zero.

Optional Feature:
- Macro FP_DIV_EXC_FLAGS_EN.
- When defined, adds output port flags[3:0] = {invalid, div_by_zero, overflow, underflow}:
  - Registered and updated in the same cycle as S, valid for the valid_out cycle, held until the next update.
  - Cleared to 0 by reset.
  - Inexact is not reported.
- When undefined: the port and its logic are absent. S/valid_out behaviour is identical in both builds.

Test Plan:
- Reset: hold rstn=1 for 3 cycles, then release; S=0 and valid_out=0 throughout reset. The first valid_out appears exactly 29 cycles after release (LOAD at the first edge).
- num1=3E9EB852 (0.31), num2=3F8F5C29 (1.12) -> S=3E8DB6DB on valid_out. S is stable on every subsequent period.
- Remaining normal-operand vectors, each -> S on valid_out:
  - num1=3F8E147B (1.11), num2=3F8147AE (1.01) -> S=3F8CAC5B
  - num1=40AE6666 (5.45), num2=404D70A4 (3.21) -> S=3FD95224
  - num1=42EA75C3 (117.23), num2=40BEB852 (5.96) -> S=419D5B10
- Special cases:
  - num1=3F800000, num2=00000000 -> 7F800000
  - num1=BF800000, num2=00000000 -> FF800000
  - 0/0 -> 7FC00000
  - 7F800000/3F800000 -> 7F800000
- Range limits:
  - 7F000000/3E800000 -> 7F800000 (overflow)
  - 00800000/7F000000 -> 00000000 (underflow)
  - Changing num1 mid-CALC does not alter the pending result.
- Reset asserted at cycle 10 of CALC: no valid_out, S=0. The operation restarts with the current inputs after release.
